// File: rtl/iir_filter_param.sv
// Time-multiplexed direct-form-I IIR filter: a single multiply-accumulate evaluates
// 2N+1 products per input sample, then saturates the result and feeds it back.
module iir_filter_param #(
  parameter int WORD_IN   = 8,
  parameter int WORD_OUT  = 2*WORD_IN+2,
  parameter int COEF_W    = 8,
  parameter int COEF_FRAC = 6,
  parameter int ORDER     = 8,
  localparam int ADDR_W   = $clog2(ORDER+1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [WORD_IN-1:0]  data_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [WORD_OUT-1:0] data_out,
  output logic                       out_valid,
  output logic                       overflow,
  input  logic                       coef_we,
  input  logic                       coef_sel,
  input  logic [ADDR_W-1:0]          coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  input  logic                       clear
);
  localparam int PROD_W = WORD_OUT + COEF_W;
  localparam int CNT_W  = $clog2(2*ORDER+1);
  localparam int ACC_W  = PROD_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2*ORDER);
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-WORD_OUT+1){1'b0}}, {(WORD_OUT-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-WORD_OUT+1){1'b1}}, {(WORD_OUT-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, state_next;

  logic signed [WORD_IN-1:0]  x_line [0:ORDER];
  logic signed [WORD_OUT-1:0] y_line [1:ORDER];
  logic signed [COEF_W-1:0]   b_coef [0:ORDER];
  logic signed [COEF_W-1:0]   a_coef [1:ORDER];
  logic [CNT_W-1:0]           step;
  logic signed [ACC_W-1:0]    acc;

  logic                       accept;
  logic signed [WORD_OUT-1:0] mac_sample;
  logic signed [COEF_W-1:0]   mac_coef;
  logic                       mac_sub;
  logic signed [PROD_W-1:0]   product;
  logic signed [ACC_W-1:0]    mac_term;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [WORD_OUT-1:0] y_sat;
  logic                       y_ovf;

  assign in_ready = (state == IDLE);
  // clear has priority over a sample offered in the same cycle.
  assign accept   = in_ready && in_valid && !clear;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = MAC;
      MAC:     if (step == LAST_STEP) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Steps 0..N walk the b taps over x, steps N+1..2N walk the a taps over y.
  always_comb begin
    mac_sample = '0;
    mac_coef   = '0;
    mac_sub    = 1'b0;
    for (int k = 0; k <= ORDER; k++) begin
      if (int'(step) == k) begin
        mac_sample = {{(WORD_OUT-WORD_IN){x_line[k][WORD_IN-1]}}, x_line[k]};
        mac_coef   = b_coef[k];
      end
    end
    for (int k = 1; k <= ORDER; k++) begin
      if (int'(step) == ORDER + k) begin
        mac_sample = y_line[k];
        mac_coef   = a_coef[k];
        mac_sub    = 1'b1;
      end
    end
  end

  assign product  = PROD_W'(mac_sample) * PROD_W'(mac_coef);
  assign mac_term = mac_sub ? -ACC_W'(product) : ACC_W'(product);
  assign shifted  = acc >>> COEF_FRAC;

  always_comb begin
    y_sat = shifted[WORD_OUT-1:0];
    y_ovf = 1'b0;
    if (shifted > Y_MAX) begin
      y_sat = {1'b0, {(WORD_OUT-1){1'b1}}};
      y_ovf = 1'b1;
    end else if (shifted < Y_MIN) begin
      y_sat = {1'b1, {(WORD_OUT-1){1'b0}}};
      y_ovf = 1'b1;
    end
  end

  // NOTE: the delay lines and coefficient banks are small register arrays and are
  // reset explicitly; a block RAM would not allow this and would need a clear walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= ORDER; k++) begin
        x_line[k] <= '0;
        b_coef[k] <= '0;
      end
      for (int k = 1; k <= ORDER; k++) begin
        y_line[k] <= '0;
        a_coef[k] <= '0;
      end
      step      <= '0;
      acc       <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_we) begin
            for (int k = 0; k <= ORDER; k++)
              if (!coef_sel && coef_addr == ADDR_W'(k)) b_coef[k] <= coef_data;
            for (int k = 1; k <= ORDER; k++)
              if (coef_sel && coef_addr == ADDR_W'(k)) a_coef[k] <= coef_data;
          end
          if (clear) begin
            for (int k = 0; k <= ORDER; k++) x_line[k] <= '0;
            for (int k = 1; k <= ORDER; k++) y_line[k] <= '0;
          end else if (in_valid) begin
            for (int k = 1; k <= ORDER; k++) x_line[k] <= x_line[k-1];
            x_line[0] <= data_in;
            acc       <= '0;
            step      <= '0;
          end
        end
        MAC: begin
          acc  <= acc + mac_term;
          step <= step + CNT_W'(1);
        end
        DONE: begin
          data_out  <= y_sat;
          overflow  <= y_ovf;
          out_valid <= 1'b1;
          for (int k = 2; k <= ORDER; k++) y_line[k] <= y_line[k-1];
          y_line[1] <= y_sat;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iir_filter_param.sv
// Self-checking bench for iir_filter_param: directed vector table, control corner
// sequences and randomized samples checked against an arithmetic reference model.
module tb_iir_filter_param;
  localparam int ORDER = 8;
  localparam int LAT   = 2*ORDER+2;
  localparam longint Y_MAX = 131071;
  localparam longint Y_MIN = -131072;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [7:0]  data_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] data_out;
  logic               out_valid;
  logic               overflow;
  logic               coef_we;
  logic               coef_sel;
  logic [3:0]         coef_addr;
  logic signed [7:0]  coef_data;
  logic               clear;

  always #5 clk = ~clk;

  iir_filter_param #(.WORD_IN(8), .WORD_OUT(18), .COEF_W(8), .COEF_FRAC(6), .ORDER(ORDER)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .overflow(overflow), .coef_we(coef_we),
    .coef_sel(coef_sel), .coef_addr(coef_addr), .coef_data(coef_data), .clear(clear)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: coefficient banks and sample histories as plain integers.
  longint b_m [0:ORDER];
  longint a_m [1:ORDER];
  longint xh  [0:ORDER];
  longint yh  [1:ORDER];

  task automatic model_clear_hist();
    for (int k = 0; k <= ORDER; k++) xh[k] = 0;
    for (int k = 1; k <= ORDER; k++) yh[k] = 0;
  endtask

  task automatic model_reset_all();
    model_clear_hist();
    for (int k = 0; k <= ORDER; k++) b_m[k] = 0;
    for (int k = 1; k <= ORDER; k++) a_m[k] = 0;
  endtask

  task automatic model_step(input longint x, output longint y, output bit ov);
    longint s, q;
    for (int k = ORDER; k > 0; k--) xh[k] = xh[k-1];
    xh[0] = x;
    s = 0;
    for (int k = 0; k <= ORDER; k++) s += b_m[k] * xh[k];
    for (int k = 1; k <= ORDER; k++) s -= a_m[k] * yh[k];
    q = s / 64;
    if ((s % 64 != 0) && (s < 0)) q = q - 1;
    y = q;
    ov = 1'b0;
    if (q > Y_MAX) begin y = Y_MAX; ov = 1'b1; end
    else if (q < Y_MIN) begin y = Y_MIN; ov = 1'b1; end
    for (int k = ORDER; k > 1; k--) yh[k] = yh[k-1];
    yh[1] = y;
  endtask

  // Returns at a falling edge with in_ready high.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic write_coef(input bit sel, input int addr, input int val);
    wait_idle();
    coef_we = 1'b1; coef_sel = sel; coef_addr = addr[3:0]; coef_data = val[7:0];
    @(negedge clk);
    coef_we = 1'b0;
    if (addr >= 0 && addr <= ORDER) begin
      if (!sel) b_m[addr] = val;
      else if (addr != 0) a_m[addr] = val;
    end
  endtask

  task automatic do_clear();
    wait_idle();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear_hist();
  endtask

  task automatic set_cfg(input int cfg);
    for (int k = 0; k <= ORDER; k++) write_coef(1'b0, k, 0);
    for (int k = 1; k <= ORDER; k++) write_coef(1'b1, k, 0);
    case (cfg)
      0: write_coef(1'b0, 0, 64);
      1: begin write_coef(1'b0, 0, 64); write_coef(1'b0, 1, 64); end
      2: begin write_coef(1'b0, 0, 64); write_coef(1'b1, 1, -32); end
      default: begin write_coef(1'b0, 0, 127); write_coef(1'b1, 1, -64); end
    endcase
    do_clear();
  endtask

  // Offers one sample, optionally with a b0 write at the accept edge or a b0 write
  // attempt during MAC, and checks latency and single-cycle out_valid.
  task automatic apply(input int x, input bit we_now, input int we_val, input bit poke_mid,
                       output longint y, output bit ov);
    bit got;
    got = 1'b0; y = 0; ov = 1'b0;
    wait_idle();
    data_in = x[7:0];
    in_valid = 1'b1;
    if (we_now) begin
      coef_we = 1'b1; coef_sel = 1'b0; coef_addr = 4'd0; coef_data = we_val[7:0];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    data_in  = 8'($urandom);
    for (int c = 1; c <= LAT + 20; c++) begin
      if (poke_mid && c == 3) begin
        coef_we = 1'b1; coef_sel = 1'b0; coef_addr = 4'd0; coef_data = 8'sd127;
      end else coef_we = 1'b0;
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1'b1;
        check("latency", c, LAT);
        check("ready_with_valid", in_ready, 1);
        y  = data_out;
        ov = overflow;
        @(posedge clk); #1;
        check("valid_pulse_width", out_valid, 0);
        break;
      end
    end
    coef_we = 1'b0;
    if (!got) check("out_valid_timeout", 0, 1);
  endtask

  task automatic run(input string name, input int x, output longint y, output bit ov);
    longint ey;
    bit eov;
    apply(x, 1'b0, 0, 1'b0, y, ov);
    model_step(x, ey, eov);
    check(name, y, ey);
    check({name, "_ovf"}, ov, eov);
  endtask

  typedef struct {
    int     cfg;
    int     din;
    longint exp_y;
    bit     exp_ov;
  } vec_t;

  vec_t vtab [14];

  initial begin
    longint y, ey, prev;
    bit ov, eov, seen;
    int n, prev_cfg, nonmono;
    int t [3];

    vtab[0]  = '{0,  5,  5, 1'b0};
    vtab[1]  = '{0, -7, -7, 1'b0};
    vtab[2]  = '{1,  1,  1, 1'b0};
    vtab[3]  = '{1,  0,  1, 1'b0};
    vtab[4]  = '{1,  0,  0, 1'b0};
    vtab[5]  = '{1,  0,  0, 1'b0};
    vtab[6]  = '{2, 64, 64, 1'b0};
    vtab[7]  = '{2,  0, 32, 1'b0};
    vtab[8]  = '{2,  0, 16, 1'b0};
    vtab[9]  = '{2,  0,  8, 1'b0};
    vtab[10] = '{2,  0,  4, 1'b0};
    vtab[11] = '{2,  0,  2, 1'b0};
    vtab[12] = '{2,  0,  1, 1'b0};
    vtab[13] = '{2,  0,  0, 1'b0};

    rst_n = 1'b0; data_in = '0; in_valid = 1'b0; coef_we = 1'b0; coef_sel = 1'b0;
    coef_addr = '0; coef_data = '0; clear = 1'b0;
    model_reset_all();

    // Reset held while inputs toggle randomly.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_in = 8'($urandom); in_valid = 1'($urandom); coef_we = 1'($urandom);
      coef_data = 8'($urandom); clear = 1'($urandom);
      @(posedge clk); #1;
      check("reset_data_out", data_out, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
    end
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0; clear = 1'b0; data_in = '0;
    rst_n = 1'b1;

    // Directed table: passthrough, FIR and first-order feedback responses.
    prev_cfg = -1;
    for (int i = 0; i < 14; i++) begin
      if (vtab[i].cfg != prev_cfg) begin
        set_cfg(vtab[i].cfg);
        prev_cfg = vtab[i].cfg;
      end
      apply(vtab[i].din, 1'b0, 0, 1'b0, y, ov);
      model_step(vtab[i].din, ey, eov);
      check($sformatf("table_%0d", i), y, vtab[i].exp_y);
      check($sformatf("table_%0d_ovf", i), ov, vtab[i].exp_ov);
    end

    // Coefficient write at the accept edge is used for that sample: 40*32/64 = 20.
    set_cfg(0);
    apply(40, 1'b1, 32, 1'b0, y, ov);
    b_m[0] = 32;
    model_step(40, ey, eov);
    check("write_with_accept", y, 20);

    // Coefficient write during MAC is ignored.
    set_cfg(0);
    apply(5, 1'b0, 0, 1'b1, y, ov);
    model_step(5, ey, eov);
    check("we_in_mac_same", y, 5);
    apply(10, 1'b0, 0, 1'b0, y, ov);
    model_step(10, ey, eov);
    check("we_in_mac_next", y, 10);

    // clear zeroes history and blocks a simultaneous sample.
    set_cfg(1);
    run("clear_pre", 20, y, ov);
    do_clear();
    apply(0, 1'b0, 0, 1'b0, y, ov);
    model_step(0, ey, eov);
    check("clear_restart", y, 0);
    wait_idle();
    clear = 1'b1; in_valid = 1'b1; data_in = 8'sd50;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    model_clear_hist();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("clear_beats_valid", seen, 0);
    apply(0, 1'b0, 0, 1'b0, y, ov);
    model_step(0, ey, eov);
    check("clear_beats_valid_hist", y, 0);

    // in_valid held high: accepts spaced 2N+3 clocks apart.
    set_cfg(0);
    wait_idle();
    data_in = 8'sd3; in_valid = 1'b1; n = 0;
    for (int c = 0; c < 100; c++) begin
      if (in_ready && n < 3) begin t[n] = c; n++; end
      @(posedge clk);
      if (n == 3) break;
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("held_accept_count", n, 3);
    if (n == 3) begin
      check("held_spacing_1", t[1] - t[0], 2*ORDER+3);
      check("held_spacing_2", t[2] - t[1], 2*ORDER+3);
    end
    do_clear();

    // Saturation: output climbs by 252 per sample, then clamps with overflow.
    set_cfg(3);
    nonmono = 0; prev = Y_MIN;
    for (int i = 0; i < 530; i++) begin
      run("sat", 127, y, ov);
      if (i == 0) check("sat_first", y, 252);
      if (y < prev) nonmono++;
      prev = y;
    end
    check("sat_monotonic", nonmono, 0);
    check("sat_final", y, Y_MAX);
    check("sat_final_ovf", ov, 1);

    // Random coefficients (including ignored writes) and random samples.
    set_cfg(0);
    for (int i = 0; i < 30; i++)
      write_coef(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128);
    do_clear();
    for (int i = 0; i < 40; i++)
      run("random", int'($urandom_range(0, 255)) - 128, y, ov);

    // Reset during MAC aborts the sample.
    wait_idle();
    data_in = 8'sd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset_all();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("reset_mid_mac_no_valid", seen, 0);
    check("reset_mid_mac_data_out", data_out, 0);
    write_coef(1'b0, 0, 64);
    run("after_reset", 9, y, ov);
    check("after_reset_value", y, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
